// File: rtl/fetch_decode_unit_if.sv
// Handshake and control bundle between the fetch/decode stage and its environment.
interface fetch_decode_unit_if #(
  parameter int unsigned PC_W  = 16,
  parameter int unsigned AW    = 8,
  parameter int unsigned CNT_W = 16
) ();
  logic             start;
  logic             prog_we;
  logic [AW-1:0]    prog_addr;
  logic [7:0]       prog_data;
  logic             redirect_valid;
  logic [PC_W-1:0]  redirect_pc;
  logic             out_ready;
  logic             out_valid;
  logic [PC_W-1:0]  out_pc;
  logic [1:0]       format;
  logic [3:0]       opcode;
  logic [2:0]       reg1_i;
  logic [2:0]       reg2_i;
  logic [2:0]       reg_o;
  logic [2:0]       imm;
  logic             imm_flag;
  logic             illegal;
  logic             halted;
  logic [CNT_W-1:0] retired_cnt;

  // Driver side (program loader, execute stage, branch unit)
  modport master (
    output start, prog_we, prog_addr, prog_data, redirect_valid, redirect_pc, out_ready,
    input  out_valid, out_pc, format, opcode, reg1_i, reg2_i, reg_o, imm, imm_flag,
           illegal, halted, retired_cnt
  );

  // Fetch/decode unit side
  modport slave (
    input  start, prog_we, prog_addr, prog_data, redirect_valid, redirect_pc, out_ready,
    output out_valid, out_pc, format, opcode, reg1_i, reg2_i, reg_o, imm, imm_flag,
           illegal, halted, retired_cnt
  );
endinterface

// File: rtl/fetch_decode_unit.sv
// Instruction fetch and decode stage: owns PC and instruction memory, presents
// one decoded instruction per handshake to the execute stage.
module fetch_decode_unit #(
  parameter int unsigned PC_W  = 16,
  parameter int unsigned DEPTH = 256,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  fetch_decode_unit_if.slave bus
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [1:0] FMT_C = 2'b00;
  localparam logic [1:0] FMT_I = 2'b01;
  localparam logic [1:0] FMT_M = 2'b10;
  localparam logic [1:0] FMT_X = 2'b11;
  localparam logic [7:0] HALT_INSTR = 8'hE0;

  typedef enum logic [1:0] {IDLE, RUN, HALTED} state_t;

  typedef struct packed {
    logic [1:0] format;
    logic [3:0] opcode;
    logic [2:0] reg1_i;
    logic [2:0] reg2_i;
    logic [2:0] reg_o;
    logic [2:0] imm;
    logic       imm_flag;
    logic       illegal;
  } dec_t;

  // Split one instruction byte into its format-dependent fields
  function automatic dec_t decode(input logic [7:0] instr);
    dec_t d;
    d          = '0;
    d.opcode   = instr[7:4];
    d.imm      = instr[3:1];
    d.imm_flag = instr[0];
    d.illegal  = (instr[7:4] == 4'hF);
    case (instr[7:4])
      4'h2, 4'h4: begin
        d.format = FMT_C;
        d.reg_o  = instr[0] ? 3'd3 : 3'd2;
      end
      4'h9, 4'hD: begin
        d.format = FMT_I;
        d.reg1_i = instr[3:1];
        d.reg2_i = instr[3:1] + 3'd1;
        d.reg_o  = instr[3:1];
      end
      4'hE, 4'hF: d.format = FMT_X;
      default: begin
        d.format = FMT_M;
        d.reg1_i = {1'b0, instr[3:2]};
        d.reg2_i = {1'b0, instr[3:2]} + 3'd1;
        d.reg_o  = {1'b1, instr[1:0]};
      end
    endcase
    return d;
  endfunction

  logic [7:0]       mem_q [DEPTH];
  state_t           state_q, state_d;
  logic [PC_W-1:0]  pc_q, pc_d;
  logic             out_valid_q, out_valid_d;
  logic [PC_W-1:0]  out_pc_q, out_pc_d;
  dec_t             dec_q, dec_d;
  logic             halted_q, halted_d;
  logic [CNT_W-1:0] retired_q, retired_d;
  logic [7:0]       instr_c;
  logic             retire_c;

  // Fetch port: addresses past the end of memory read as HALT
  always_comb begin
    instr_c = HALT_INSTR;
    if ({1'b0, pc_q} < (PC_W+1)'(DEPTH)) instr_c = mem_q[AW'(pc_q)];
  end

  // Program load only while the fetch stage is not running
  always_ff @(posedge clk) begin
    if (bus.prog_we && (state_q != RUN)) mem_q[bus.prog_addr] <= bus.prog_data;
  end

  // Next-state: start/advance/redirect/halt sequencing and retire counting
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    out_valid_d = out_valid_q;
    out_pc_d    = out_pc_q;
    dec_d       = dec_q;
    retired_d   = retired_q;
    retire_c    = out_valid_q && bus.out_ready;

    if (retire_c && (retired_q != '1)) retired_d = retired_q + CNT_W'(1);

    case (state_q)
      RUN: begin
        if (bus.redirect_valid) begin
          pc_d        = bus.redirect_pc;
          out_valid_d = 1'b0;
        end else if (!out_valid_q || bus.out_ready) begin
          dec_d       = decode(instr_c);
          out_pc_d    = pc_q;
          out_valid_d = 1'b1;
          pc_d        = pc_q + PC_W'(1);
          if (instr_c[7:4] == 4'hE) state_d = HALTED;
        end
      end
      default: begin
        if (retire_c) out_valid_d = 1'b0;
        if (bus.start) begin
          state_d     = RUN;
          pc_d        = '0;
          out_valid_d = 1'b0;
        end
      end
    endcase

    halted_d = (state_d == HALTED);
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      pc_q        <= '0;
      out_valid_q <= 1'b0;
      out_pc_q    <= '0;
      dec_q       <= '0;
      halted_q    <= 1'b0;
      retired_q   <= '0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      out_valid_q <= out_valid_d;
      out_pc_q    <= out_pc_d;
      dec_q       <= dec_d;
      halted_q    <= halted_d;
      retired_q   <= retired_d;
    end
  end

  assign bus.out_valid   = out_valid_q;
  assign bus.out_pc      = out_pc_q;
  assign bus.format      = dec_q.format;
  assign bus.opcode      = dec_q.opcode;
  assign bus.reg1_i      = dec_q.reg1_i;
  assign bus.reg2_i      = dec_q.reg2_i;
  assign bus.reg_o       = dec_q.reg_o;
  assign bus.imm         = dec_q.imm;
  assign bus.imm_flag    = dec_q.imm_flag;
  assign bus.illegal     = dec_q.illegal;
  assign bus.halted      = halted_q;
  assign bus.retired_cnt = retired_q;
endmodule

// File: tb/tb_fetch_decode_unit.sv
// Directed bench for fetch_decode_unit: decode table plus stall, redirect,
// reset, illegal/write-protect and end-of-memory sequences.
module tb_fetch_decode_unit;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int tests_run = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  fetch_decode_unit_if #(.PC_W(16), .AW(8), .CNT_W(16)) m_if ();
  fetch_decode_unit_if #(.PC_W(16), .AW(3), .CNT_W(16)) s_if ();

  fetch_decode_unit #(.PC_W(16), .DEPTH(256), .CNT_W(16)) u_dut (
    .clk(clk), .rst_n(rst_n), .bus(m_if.slave));
  fetch_decode_unit #(.PC_W(16), .DEPTH(8), .CNT_W(16)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .bus(s_if.slave));

  typedef struct {
    logic [7:0] instr;
    logic [1:0] fmt;
    logic [3:0] opc;
    logic [2:0] r1;
    logic [2:0] r2;
    logic [2:0] ro;
    logic [2:0] imm;
    logic       imf;
    logic       ill;
  } vec_t;

  vec_t vecs [8];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_dec(input string name, input int idx);
    check({name, ".valid"},  32'(m_if.out_valid), 32'd1);
    check({name, ".format"}, 32'(m_if.format),    32'(vecs[idx].fmt));
    check({name, ".opcode"}, 32'(m_if.opcode),    32'(vecs[idx].opc));
    check({name, ".reg1_i"}, 32'(m_if.reg1_i),    32'(vecs[idx].r1));
    check({name, ".reg2_i"}, 32'(m_if.reg2_i),    32'(vecs[idx].r2));
    check({name, ".reg_o"},  32'(m_if.reg_o),     32'(vecs[idx].ro));
    check({name, ".imm"},    32'(m_if.imm),       32'(vecs[idx].imm));
    check({name, ".immf"},   32'(m_if.imm_flag),  32'(vecs[idx].imf));
    check({name, ".illegal"},32'(m_if.illegal),   32'(vecs[idx].ill));
  endtask

  task automatic load(input logic [7:0] addr, input logic [7:0] data);
    m_if.prog_we   = 1'b1;
    m_if.prog_addr = addr;
    m_if.prog_data = data;
    step();
    m_if.prog_we   = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
  endtask

  task automatic do_start();
    m_if.start = 1'b1;
    step();
    m_if.start = 1'b0;
  endtask

  initial begin
    //          instr  fmt   op    r1 r2 ro imm f ill
    vecs[0] = '{8'h42, 2'd0, 4'h4, 0, 0, 2, 1, 0, 0};
    vecs[1] = '{8'hD4, 2'd1, 4'hD, 2, 3, 2, 2, 0, 0};
    vecs[2] = '{8'h43, 2'd0, 4'h4, 0, 0, 3, 1, 1, 0};
    vecs[3] = '{8'h94, 2'd1, 4'h9, 2, 3, 2, 2, 0, 0};
    vecs[4] = '{8'h6A, 2'd2, 4'h6, 2, 3, 6, 5, 0, 0};
    vecs[5] = '{8'hE0, 2'd3, 4'hE, 0, 0, 0, 0, 0, 0};
    vecs[6] = '{8'hF2, 2'd3, 4'hF, 0, 0, 0, 1, 0, 1};
    vecs[7] = '{8'h70, 2'd2, 4'h7, 0, 1, 4, 0, 0, 0};

    m_if.start = 0; m_if.prog_we = 0; m_if.prog_addr = '0; m_if.prog_data = '0;
    m_if.redirect_valid = 0; m_if.redirect_pc = '0; m_if.out_ready = 0;
    s_if.start = 0; s_if.prog_we = 0; s_if.prog_addr = '0; s_if.prog_data = '0;
    s_if.redirect_valid = 0; s_if.redirect_pc = '0; s_if.out_ready = 0;

    // Reset state
    step();
    do_reset();
    check("rst.valid",   32'(m_if.out_valid),   32'd0);
    check("rst.halted",  32'(m_if.halted),      32'd0);
    check("rst.retired", 32'(m_if.retired_cnt), 32'd0);
    check("rst.out_pc",  32'(m_if.out_pc),      32'd0);

    // Straight-line program, full throughput
    for (int i = 0; i < 6; i++) load(8'(i), vecs[i].instr);
    do_start();
    check("start.valid", 32'(m_if.out_valid), 32'd0);
    m_if.out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      check($sformatf("run%0d.pc", i), 32'(m_if.out_pc), 32'(i));
      check_dec($sformatf("run%0d", i), i);
    end
    check("run.halted_at_halt", 32'(m_if.halted), 32'd1);
    step();
    check("run.valid_after", 32'(m_if.out_valid),   32'd0);
    check("run.halted",      32'(m_if.halted),      32'd1);
    check("run.retired",     32'(m_if.retired_cnt), 32'd6);

    // Back-pressure at out_pc=1
    do_reset();
    do_start();
    m_if.out_ready = 1'b1;
    step();
    step();
    m_if.out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      check($sformatf("stall%0d.pc", i), 32'(m_if.out_pc), 32'd1);
      check_dec($sformatf("stall%0d", i), 1);
      check($sformatf("stall%0d.retired", i), 32'(m_if.retired_cnt), 32'd1);
    end
    m_if.out_ready = 1'b1;
    step();
    check("stall.release_pc", 32'(m_if.out_pc),      32'd2);
    check("stall.release_rc", 32'(m_if.retired_cnt), 32'd2);
    check_dec("stall.release", 2);

    // Redirect to 4 while out_pc=1 is accepted
    do_reset();
    do_start();
    m_if.out_ready = 1'b1;
    step();
    step();
    check("redir.pre_pc", 32'(m_if.out_pc), 32'd1);
    m_if.redirect_valid = 1'b1;
    m_if.redirect_pc    = 16'd4;
    step();
    m_if.redirect_valid = 1'b0;
    check("redir.flush",   32'(m_if.out_valid),   32'd0);
    check("redir.retired", 32'(m_if.retired_cnt), 32'd2);
    step();
    check("redir.target_pc", 32'(m_if.out_pc), 32'd4);
    check_dec("redir.target", 4);
    step();
    check("redir.next_pc", 32'(m_if.out_pc), 32'd5);
    step();
    check("redir.retired_end", 32'(m_if.retired_cnt), 32'd4);

    // Reset mid-run with a valid output pending
    do_start();
    m_if.out_ready = 1'b0;
    step();
    check("mrst.pre_valid", 32'(m_if.out_valid), 32'd1);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    check("mrst.valid",   32'(m_if.out_valid),   32'd0);
    check("mrst.retired", 32'(m_if.retired_cnt), 32'd0);
    check("mrst.halted",  32'(m_if.halted),      32'd0);
    check("mrst.out_pc",  32'(m_if.out_pc),      32'd0);
    check("mrst.format",  32'(m_if.format),      32'd0);
    step();
    check("mrst.idle_valid", 32'(m_if.out_valid), 32'd0);
    do_start();
    m_if.out_ready = 1'b1;
    step();
    check("mrst.rerun_pc", 32'(m_if.out_pc), 32'd0);
    check_dec("mrst.rerun", 0);

    // Illegal opcode does not stop fetch; writes during RUN are dropped
    do_reset();
    load(8'd0, 8'hF2);
    load(8'd1, 8'h70);
    load(8'd2, 8'hE0);
    do_start();
    m_if.out_ready = 1'b1;
    step();
    check("ill.pc0", 32'(m_if.out_pc), 32'd0);
    check_dec("ill.f2", 6);
    m_if.prog_we   = 1'b1;
    m_if.prog_addr = 8'd2;
    m_if.prog_data = 8'h43;
    step();
    check("ill.pc1", 32'(m_if.out_pc), 32'd1);
    check_dec("ill.next", 7);
    step();
    m_if.prog_we = 1'b0;
    check("ill.pc2", 32'(m_if.out_pc), 32'd2);
    check_dec("ill.halt", 5);
    check("ill.halted", 32'(m_if.halted), 32'd1);
    step();
    check("ill.retired", 32'(m_if.retired_cnt), 32'd3);

    // DEPTH=8: running off the end of memory reads HALT
    do_reset();
    for (int i = 0; i < 8; i++) begin
      s_if.prog_we   = 1'b1;
      s_if.prog_addr = 3'(i);
      s_if.prog_data = 8'h70;
      step();
    end
    s_if.prog_we = 1'b0;
    s_if.start   = 1'b1;
    step();
    s_if.start     = 1'b0;
    s_if.out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step();
      check($sformatf("d8.pc%0d", i),  32'(s_if.out_pc), 32'(i));
      check($sformatf("d8.op%0d", i),  32'(s_if.opcode), 32'h7);
    end
    check("d8.reg_o", 32'(s_if.reg_o), 32'd4);
    check("d8.not_halted", 32'(s_if.halted), 32'd0);
    step();
    check("d8.end_pc",  32'(s_if.out_pc),    32'd8);
    check("d8.end_op",  32'(s_if.opcode),    32'hE);
    check("d8.end_fmt", 32'(s_if.format),    32'd3);
    check("d8.halted",  32'(s_if.halted),    32'd1);
    check("d8.valid",   32'(s_if.out_valid), 32'd1);
    step();
    check("d8.retired", 32'(s_if.retired_cnt), 32'd9);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule

// File: doc/fetch_decode_unit.md
Name: fetch_decode_unit

Overview:
Parametrised, sequential instruction-fetch and decode stage for the 8-bit C/I/M/X-format ISA. It holds a writable instruction memory and owns the program counter. It fetches one instruction per accepted handshake, decodes it into format, opcode, register and immediate fields, and presents the result through a registered valid/ready interface to the execute stage. It also supports redirect for jumps and branches, HALT detection, and a retired-instruction counter.

Parameters:
PC_W, 16, program-counter width; PC wraps modulo 2^PC_W.
DEPTH, 256, instruction-memory entries (8-bit each); address width AW = clog2(DEPTH).
CNT_W, 16, retired-instruction counter width.

Ports:
clk  in  1  clock; all state updates on rising edge
rst_n  in  1  synchronous active-low reset
start  in  1  pulse: enter RUN at pc=0 (honoured in IDLE/HALTED only)
prog_we  in  1  instruction-memory write enable (honoured in IDLE/HALTED only)
prog_addr  in  AW  write address
prog_data  in  8  write data
redirect_valid  in  1  jump/branch taken
redirect_pc  in  PC_W  redirect target
out_ready  in  1  execute stage accepts current output
out_valid  out  1  decoded instruction valid
out_pc  out  PC_W  address of the presented instruction
format  out  2  00=C, 01=I, 10=M, 11=X
opcode  out  4  instr[7:4]
reg1_i, reg2_i, reg_o  out  3 each  source and destination register indices
imm  out  3  instr[3:1]
imm_flag  out  1  instr[0]
illegal  out  1  presented opcode is 1111 (TBA)
halted  out  1  FSM in HALTED
retired_cnt  out  CNT_W  count of accepted instructions

Behaviour:
- Reset (rst_n=0 at clk edge): FSM=IDLE, pc=0, out_valid=0, all decode outputs=0, illegal=0, halted=0, retired_cnt=0. Memory contents are not reset. Reset has priority over every other input, including mid-RUN.
- Memory: synchronous write of prog_data on a prog_we edge when FSM is IDLE or HALTED; prog_we is ignored in RUN. Read is combinational at pc. Any pc >= DEPTH reads 8'hE0 (HALT).
- FSM states: IDLE, RUN, HALTED.
  - IDLE/HALTED + start: go to RUN, pc=0, out_valid=0.
  - RUN: see advance, redirect and HALT rules below.
- Advance: in RUN, advance = (!out_valid || out_ready).
  - On advance, load the output register with the decode of mem[pc], set out_pc=pc, out_valid=1, pc=pc+1 (wraps).
  - Fetch-to-valid latency is 1 cycle. Sustained throughput is 1 instruction/cycle while out_ready=1.
  - While out_valid=1 and out_ready=0, all outputs are held stable.
- Retire: out_valid && out_ready increments retired_cnt, saturating at all-ones. This applies in HALTED too, so the HALT instruction is counted when accepted.
- Redirect: in RUN, redirect_valid has priority over advance. Set pc=redirect_pc and out_valid=0 (flush) that cycle; fetch resumes the next cycle. If out_valid && out_ready in the same cycle, the instruction still retires. Redirect is ignored in IDLE/HALTED.
- HALT: when the fetched opcode is 1110, it is presented normally (out_valid=1, format=X), the FSM goes to HALTED, and pc freezes at the HALT address+1. In HALTED, out_valid stays 1 until accepted, then 0. halted=1 in HALTED.
- Decode (registered):
  - Format: opcodes 0010 and 0100 are C; 1001 and 1101 are I; 1110 and 1111 are X; all others are M.
  - C: reg1_i=reg2_i=0; reg_o = instr[0] ? 3 : 2.
  - I: reg1_i=instr[3:1]; reg2_i=reg1_i+1 mod 8; reg_o=reg1_i.
  - M: reg1_i={0,instr[3:2]}; reg2_i=reg1_i+1; reg_o={1,instr[1:0]}.
  - X: all three register fields are 0.
  - imm=instr[3:1] and imm_flag=instr[0] in every format.
  - illegal=1 iff opcode is 1111. An illegal opcode does not stop fetch.
- Simultaneous start and prog_we in IDLE: the write commits and start takes effect in the same edge.

Test Plan:
- Load mem[0..4] = 42,D4,43,94,6A, then E0 at 5; start with out_ready=1. Required: six valid outputs on consecutive cycles, out_pc 0..5. Entry 2 (43): C, reg_o=3. Entry 3 (94): I, reg1_i=2, reg2_i=3, reg_o=2. Entry 4 (6A): M, reg1_i=2, reg2_i=3, reg_o=6. Then halted=1 and retired_cnt=6.
- Same program with out_ready held 0 for 3 cycles at out_pc=1. Required: outputs stable for all 3 cycles, no pc skip, retired_cnt unchanged until release.
- redirect_valid with redirect_pc=4 while out_pc=1 is valid and accepted. Required: next cycle out_valid=0; the following cycle out_pc=4; entries 2 and 3 are never presented.
- DEPTH=8, mem[0..7] = 70 (ADD), run. Required: out_pc=8 decodes as HALT (opcode E, format X) and FSM enters HALTED.
- Store F2 and assert prog_we during RUN. Required: illegal=1 at that entry, fetch continues, and the write is ignored (memory unchanged after halt).
- rst_n=0 mid-RUN with out_valid=1. Required: next cycle out_valid=0, pc=0, FSM=IDLE, retired_cnt=0; start re-runs the preserved program.
